lc3_mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the LC3 instruction-fetch port (pc/instrmem_rd) and data port (Data_addr/Data_rd/Data_din).
- Generates complete_instr and complete_data back to the core.
- Sits between the LC3 DUT and the memory model; replaces the two independent memory responders in the bench environment.
- Data accesses have priority. A starvation counter guarantees forward progress on fetch.

---
 rtl/lc3_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_arbiter
//  Description : Shares one single-port, fixed-latency unified memory between
//                the LC3 instruction-fetch port and data port. Data accesses
//                win ties unless fetch has waited STARVE_MAX data grants.
//  Revision    : 1.0  initial release
// ============================================================================
module lc3_mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          complete_instr,
    input  logic          d_req,
    input  logic          d_rd,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          complete_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int c_starve_w = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int c_cnt_w    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);
    localparam logic [c_cnt_w-1:0]    c_lat_load   = c_cnt_w'(MEM_LAT);
    localparam logic [c_cnt_w-1:0]    c_cnt_last   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_starve_w-1:0] r_starve_cnt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_we;

    logic                  w_starve_full;
    logic                  w_grant_data;

    // With STARVE_MAX = 0 fetch is always considered starved, so it wins every tie
    generate
        if (STARVE_MAX == 0) begin : g_starve_zero
            assign w_starve_full = 1'b1;
        end else begin : g_starve_cmp
            assign w_starve_full = (r_starve_cnt >= c_starve_max);
        end
    endgenerate

    // Grant decision for the current IDLE cycle: data wins unless fetch is starved
    always_comb begin
        w_grant_data = d_req && !(i_req && w_starve_full);
    end

    assign busy = (r_state != S_IDLE);

    // Access sequencer: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_starve_cnt   <= '0;
            r_cnt          <= '0;
            r_we           <= 1'b0;
            owner          <= 1'b0;
            i_rdata        <= '0;
            d_rdata        <= '0;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            // Memory strobe and completion pulses are single-cycle by default
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;

            case (r_state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        // The memory command registers double as the request latch,
                        // so later changes on the requester inputs are ignored
                        owner     <= w_grant_data;
                        r_we      <= w_grant_data && !d_rd;
                        mem_en    <= 1'b1;
                        mem_we    <= w_grant_data && !d_rd;
                        mem_addr  <= w_grant_data ? d_addr : i_addr;
                        mem_wdata <= w_grant_data ? d_wdata : '0;
                        if (!w_grant_data) begin
                            r_starve_cnt <= '0;
                        end else if (i_req && (r_starve_cnt != c_starve_max)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_cnt   <= c_lat_load;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Last wait cycle: mem_rdata is valid now, so RESP sees it registered
                    if (r_cnt == c_cnt_last) begin
                        complete_instr <= !owner;
                        complete_data  <= owner;
                        if (!r_we) begin
                            if (owner) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                i_rdata <= mem_rdata;
                            end
                        end
                        r_state <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_mem_arbiter
//  Description : Self-checking bench for lc3_mem_arbiter. Instance A uses
//                MEM_LAT=2/STARVE_MAX=2 and is tracked every cycle by a
//                transaction-level schedule model; instance B uses
//                MEM_LAT=3/STARVE_MAX=0 for the fetch-always-wins case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lc3_mem_arbiter;

    localparam int LAT_A    = 2;
    localparam int STARVE_A = 2;
    localparam int LAT_B    = 3;
    localparam int STARVE_B = 0;

    logic        clock;
    logic        reset;

    logic        i_req, complete_instr, d_req, d_rd, complete_data;
    logic        mem_en, mem_we, busy, owner;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        i_req_b, complete_instr_b, d_req_b, d_rd_b, complete_data_b;
    logic        mem_en_b, mem_we_b, busy_b, owner_b;
    logic [15:0] i_addr_b, i_rdata_b, d_addr_b, d_wdata_b, d_rdata_b;
    logic [15:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

    lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT_A), .STARVE_MAX(STARVE_A)) u_dut_a (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .complete_instr(complete_instr),
        .d_req(d_req), .d_rd(d_rd), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .complete_data(complete_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    lc3_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT_B), .STARVE_MAX(STARVE_B)) u_dut_b (
        .clock(clock), .reset(reset),
        .i_req(i_req_b), .i_addr(i_addr_b), .i_rdata(i_rdata_b), .complete_instr(complete_instr_b),
        .d_req(d_req_b), .d_rd(d_rd_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_rdata(d_rdata_b),
        .complete_data(complete_data_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .busy(busy_b), .owner(owner_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Power-on memory contents: 16'h1021 at 16'h3000, a simple pattern elsewhere
    function automatic logic [15:0] pat(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1021 : (a ^ 16'h5A5A);
    endfunction

    // Memory A: fixed-latency read pipeline plus written-location overlay
    bit          wvld [0:65535];
    logic [15:0] wval [0:65535];
    logic [15:0] pipe_a [0:LAT_A-1];
    always @(posedge clock) begin
        pipe_a[0] <= mem_en ? (wvld[mem_addr] ? wval[mem_addr] : pat(mem_addr)) : 16'hDEAD;
        for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
        if (mem_en && mem_we) begin
            wvld[mem_addr] <= 1'b1;
            wval[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = pipe_a[LAT_A-1];

    // Memory B: read-only pattern memory
    logic [15:0] pipe_b [0:LAT_B-1];
    always @(posedge clock) begin
        pipe_b[0] <= mem_en_b ? pat(mem_addr_b) : 16'hDEAD;
        for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
    end
    assign mem_rdata_b = pipe_b[LAT_B-1];

    // Counters and reference-model state
    int          n_cmp, n_bad, cyc;
    int          next_sample, t_start, starve;
    bit          active, t_own, t_we, e_owner;
    logic [15:0] t_addr, t_wdata, t_rdata, e_irdata, e_drdata;
    logic [15:0] shadow [int];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : pat(a);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: model arbitration on the current inputs, advance, check A outputs
    task automatic step();
        bit rst_now;
        bit gd;
        bit e_busy, e_en, e_done;
        rst_now = reset;
        if (!rst_now && cyc == next_sample) begin
            if (i_req || d_req) begin
                gd      = d_req && !(i_req && starve >= STARVE_A);
                t_own   = gd;
                t_we    = gd && !d_rd;
                t_addr  = gd ? d_addr : i_addr;
                t_wdata = gd ? d_wdata : 16'h0000;
                t_rdata = ref_rd(t_addr);
                if (t_we) shadow[int'(t_addr)] = t_wdata;
                if (gd) begin
                    if (i_req && starve < STARVE_A) starve++;
                end else begin
                    starve = 0;
                end
                t_start     = cyc;
                active      = 1'b1;
                next_sample = cyc + 3 + LAT_A;
            end else begin
                next_sample = cyc + 1;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        if (rst_now) begin
            active      = 1'b0;
            starve      = 0;
            next_sample = cyc;
            e_irdata    = 16'h0000;
            e_drdata    = 16'h0000;
            e_owner     = 1'b0;
        end
        e_busy = active && cyc >= t_start + 1 && cyc <= t_start + 2 + LAT_A;
        e_en   = active && cyc == t_start + 1;
        e_done = active && cyc == t_start + 2 + LAT_A;
        if (e_en) e_owner = t_own;
        if (e_done) begin
            if (!t_own) e_irdata = t_rdata;
            else if (!t_we) e_drdata = t_rdata;
        end
        chk1 ("busy",           busy,           e_busy);
        chk1 ("mem_en",         mem_en,         e_en);
        chk1 ("mem_we",         mem_we,         e_en && t_we);
        chk16("mem_addr",       mem_addr,       e_en ? t_addr : 16'h0000);
        chk16("mem_wdata",      mem_wdata,      e_en ? t_wdata : 16'h0000);
        chk1 ("complete_instr", complete_instr, e_done && !t_own);
        chk1 ("complete_data",  complete_data,  e_done && t_own);
        chk16("i_rdata",        i_rdata,        e_irdata);
        chk16("d_rdata",        d_rdata,        e_drdata);
        chk1 ("owner",          owner,          e_owner);
        if (e_done) active = 1'b0;
    endtask

    // Step until the wanted completion pulse appears, bounded
    task automatic run_until(input bit want_d, output int done_cyc);
        bit got;
        got      = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (want_d ? complete_data : complete_instr) begin
                got      = 1'b1;
                done_cyc = cyc;
            end
        end
        if (want_d) chk1("done_data", got, 1'b1);
        else        chk1("done_instr", got, 1'b1);
    endtask

    initial begin
        int       t0, dn, nd;
        bit       got;
        logic [5:0] order;

        n_cmp = 0; n_bad = 0; cyc = 0;
        next_sample = 0; starve = 0; active = 1'b0;
        t_start = 0; t_own = 1'b0; t_we = 1'b0;
        t_addr = '0; t_wdata = '0; t_rdata = '0;
        e_irdata = '0; e_drdata = '0; e_owner = 1'b0;

        reset = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_rd = 1'b0; d_addr = '0; d_wdata = '0;
        i_req_b = 1'b0; i_addr_b = '0; d_req_b = 1'b0; d_rd_b = 1'b0; d_addr_b = '0; d_wdata_b = '0;

        // Reset state
        step();
        step();
        chk1 ("b_rst_busy",  busy_b,           1'b0);
        chk1 ("b_rst_owner", owner_b,          1'b0);
        chk1 ("b_rst_ci",    complete_instr_b, 1'b0);
        chk1 ("b_rst_cd",    complete_data_b,  1'b0);
        chk1 ("b_rst_en",    mem_en_b,         1'b0);
        chk1 ("b_rst_we",    mem_we_b,         1'b0);
        chk16("b_rst_addr",  mem_addr_b,       16'h0000);
        chk16("b_rst_wdata", mem_wdata_b,      16'h0000);
        chk16("b_rst_ird",   i_rdata_b,        16'h0000);
        chk16("b_rst_drd",   d_rdata_b,        16'h0000);
        reset = 1'b0;

        // Fetch only
        i_req = 1'b1; i_addr = 16'h3000; t0 = cyc;
        run_until(1'b0, dn);
        chk16("fetch_latency", 16'(dn - t0), 16'(2 + LAT_A));
        chk16("fetch_data", i_rdata, 16'h1021);
        i_req = 1'b0;
        step();

        // Data write, d_rdata must keep its reset value
        d_req = 1'b1; d_rd = 1'b0; d_addr = 16'h4000; d_wdata = 16'hBEEF; t0 = cyc;
        run_until(1'b1, dn);
        chk16("write_latency", 16'(dn - t0), 16'(2 + LAT_A));
        chk16("write_drdata_held", d_rdata, 16'h0000);
        d_req = 1'b0;
        step();

        // Read back
        d_req = 1'b1; d_rd = 1'b1; d_addr = 16'h4000;
        run_until(1'b1, dn);
        chk16("readback", d_rdata, 16'hBEEF);
        d_req = 1'b0;
        step();

        // Contention: both held, expect D D I D D I
        i_req = 1'b1; i_addr = 16'h3002; d_req = 1'b1; d_rd = 1'b1; d_addr = 16'h4000;
        order = '0; nd = 0;
        for (int k = 0; k < 60 && nd < 6; k++) begin
            step();
            if (complete_data || complete_instr) begin
                order = {order[4:0], complete_data};
                nd++;
            end
        end
        chk16("grant_order", 16'(order), 16'b110110);
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Address change during WAIT has no effect
        i_req = 1'b1; i_addr = 16'h3000; t0 = cyc;
        step();
        step();
        i_addr = 16'h3005;
        run_until(1'b0, dn);
        chk16("addrchg_latency", 16'(dn - t0), 16'(2 + LAT_A));
        chk16("addrchg_data", i_rdata, 16'h1021);
        i_req = 1'b0;
        step();

        // Reset during WAIT aborts the access
        i_req = 1'b1; i_addr = 16'h3001;
        step();
        step();
        reset = 1'b1;
        step();
        chk1 ("rstwait_busy", busy, 1'b0);
        chk1 ("rstwait_ci", complete_instr, 1'b0);
        chk1 ("rstwait_en", mem_en, 1'b0);
        chk16("rstwait_ird", i_rdata, 16'h0000);
        reset = 1'b0; t0 = cyc;
        run_until(1'b0, dn);
        chk16("refetch_latency", 16'(dn - t0), 16'(2 + LAT_A));
        chk16("refetch_data", i_rdata, pat(16'h3001));
        i_req = 1'b0;
        step();

        // Instance B, STARVE_MAX=0: simultaneous requests, fetch first
        i_req_b = 1'b1; i_addr_b = 16'h3000; d_req_b = 1'b1; d_rd_b = 1'b1; d_addr_b = 16'h5000;
        t0 = cyc; got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (complete_instr_b || complete_data_b) got = 1'b1;
        end
        chk1 ("b_first_fetch", complete_instr_b, 1'b1);
        chk1 ("b_first_not_data", complete_data_b, 1'b0);
        chk1 ("b_first_owner", owner_b, 1'b0);
        chk16("b_fetch_latency", 16'(cyc - t0), 16'(2 + LAT_B));
        chk16("b_fetch_data", i_rdata_b, 16'h1021);
        i_req_b = 1'b0; t0 = cyc + 1; got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            if (complete_data_b) got = 1'b1;
        end
        chk1 ("b_data_done", got, 1'b1);
        chk16("b_data_latency", 16'(cyc - t0), 16'(2 + LAT_B));
        chk16("b_data_value", d_rdata_b, pat(16'h5000));
        chk1 ("b_data_owner", owner_b, 1'b1);
        d_req_b = 1'b0;
        step();

        // Randomized traffic on instance A against the schedule model
        for (int k = 0; k < 400; k++) begin
            if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req  = 1'b1;
                    i_addr = 16'h3000 + 16'($urandom_range(0, 7));
                end
            end else if (complete_instr) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else i_addr = 16'h3000 + 16'($urandom_range(0, 7));
            end else if ($urandom_range(0, 15) == 0) begin
                i_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                i_addr = 16'h3000 + 16'($urandom_range(0, 7));
            end

            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req   = 1'b1;
                    d_rd    = 1'($urandom_range(0, 1));
                    d_addr  = 16'h4000 + 16'($urandom_range(0, 7));
                    d_wdata = 16'($urandom);
                end
            end else if (complete_data) begin
                if ($urandom_range(0, 1) == 0) begin
                    d_req = 1'b0;
                end else begin
                    d_rd    = 1'($urandom_range(0, 1));
                    d_addr  = 16'h4000 + 16'($urandom_range(0, 7));
                    d_wdata = 16'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                d_addr  = 16'h4000 + 16'($urandom_range(0, 7));
                d_wdata = 16'($urandom);
            end

            reset = ($urandom_range(0, 99) == 0);
            step();
        end

        reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
